// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_port_arbiter_if                                             |
// | Purpose : Bundles the two requester ports, the single-port RAM port and    |
// |           the busy flag of dmem_port_arbiter.                              |
// | Ports   : mX_req/we/lock/addr/wdata  requester -> arbiter                  |
// |           mX_gnt/rvalid/rdata        arbiter -> requester                  |
// |           ram_wen/adr/dat_o          arbiter -> RAM                        |
// |           ram_dat_i                  RAM -> arbiter (one cycle after adr)  |
// |           busy                       arbiter -> observer                   |
// | Modports: slave  = arbiter side, master = requesters and RAM side          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic              m0_lock;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic              m1_lock;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;

   logic              ram_wen;
   logic [ADDR_W-1:0] ram_adr;
   logic [DATA_W-1:0] ram_dat_o;
   logic [DATA_W-1:0] ram_dat_i;

   logic              busy;

   modport slave (
      input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output ram_wen, ram_adr, ram_dat_o,
      input  ram_dat_i,
      output busy
   );

   modport master (
      output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  ram_wen, ram_adr, ram_dat_o,
      output ram_dat_i,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_port_arbiter                                                |
// | Purpose : Shares a single-port synchronous-read data RAM between the CPU   |
// |           load/store path (master 0) and the UART upload / debug port      |
// |           (master 1). Round-robin on ties, optional burst lock, and a      |
// |           starvation breaker that forces the waiting master in after       |
// |           WAIT_MAX blocked cycles. Read data returns one cycle after grant.|
// | Ports   : clock     system clock, rising edge                              |
// |           rst       asynchronous active-high reset                         |
// |           bus       dmem_port_arbiter_if.slave (requesters, RAM, busy)     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dmem_port_arbiter #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 32,
   parameter int WAIT_MAX = 8     // 1..255
) (
   input  logic                 clock,
   input  logic                 rst,
   dmem_port_arbiter_if.slave   bus
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_OWN0 = 2'd1;
   localparam logic [1:0] c_ST_OWN1 = 2'd2;

   // Last blocked-cycle count before the breaker fires.
   localparam logic [7:0] c_WAIT_LAST = 8'(WAIT_MAX - 1);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic              r_last;          // 1 = master 1 was granted last
   logic [7:0]        r_wait_cnt;
   logic [7:0]        w_wait_cnt_next;
   logic              r_force;
   logic              w_force_next;
   logic              r_rd0;
   logic              r_rd1;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_forced;
   logic              w_blocked;
   logic              w_ram_wen;
   logic [ADDR_W-1:0] w_ram_adr;
   logic [DATA_W-1:0] w_ram_dat;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state. A forced grant never installs a new owner, so the
   // previous owner has to re-arbitrate from IDLE.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = c_ST_IDLE;
      if (w_gnt0 && bus.m0_lock && !w_forced) begin
         w_state_next = c_ST_OWN0;
      end else if (w_gnt1 && bus.m1_lock && !w_forced) begin
         w_state_next = c_ST_OWN1;
      end
   end

   // ------------------------------------------------------------------
   // FSM: outputs (grant selection and RAM drive)
   // ------------------------------------------------------------------
   always_comb begin
      w_gnt0    = 1'b0;
      w_gnt1    = 1'b0;
      w_forced  = 1'b0;
      w_ram_wen = 1'b0;
      w_ram_adr = '0;
      w_ram_dat = '0;

      case (r_state)
         c_ST_OWN0: begin
            // The breaker only takes effect if the waiter is still asking.
            if (r_force && bus.m1_req) begin
               w_gnt1   = 1'b1;
               w_forced = 1'b1;
            end else if (bus.m0_req) begin
               w_gnt0 = 1'b1;
            end
         end
         c_ST_OWN1: begin
            if (r_force && bus.m0_req) begin
               w_gnt0   = 1'b1;
               w_forced = 1'b1;
            end else if (bus.m1_req) begin
               w_gnt1 = 1'b1;
            end
         end
         default: begin
            if (bus.m0_req && bus.m1_req) begin
               w_gnt0 = r_last;
               w_gnt1 = ~r_last;
            end else begin
               w_gnt0 = bus.m0_req;
               w_gnt1 = bus.m1_req;
            end
         end
      endcase

      if (w_gnt0) begin
         w_ram_wen = bus.m0_we;
         w_ram_adr = bus.m0_addr;
         w_ram_dat = bus.m0_wdata;
      end else if (w_gnt1) begin
         w_ram_wen = bus.m1_we;
         w_ram_adr = bus.m1_addr;
         w_ram_dat = bus.m1_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Starvation breaker. A cycle counts as blocked only if the owner keeps
   // the lock; any change of state or a dropped request restarts the count.
   // ------------------------------------------------------------------
   always_comb begin
      w_blocked = ((r_state == c_ST_OWN0) && bus.m1_req && !w_gnt1 &&
                   (w_state_next == c_ST_OWN0)) ||
                  ((r_state == c_ST_OWN1) && bus.m0_req && !w_gnt0 &&
                   (w_state_next == c_ST_OWN1));
      w_wait_cnt_next = 8'd0;
      w_force_next    = 1'b0;
      if (w_blocked) begin
         if (r_wait_cnt == c_WAIT_LAST) begin
            w_force_next = 1'b1;
         end else begin
            w_wait_cnt_next = r_wait_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_last     <= 1'b1;
         r_wait_cnt <= 8'd0;
         r_force    <= 1'b0;
         r_rd0      <= 1'b0;
         r_rd1      <= 1'b0;
      end else begin
         if (w_gnt0 || w_gnt1) begin
            r_last <= w_gnt1;
         end
         r_wait_cnt <= w_wait_cnt_next;
         r_force    <= w_force_next;
         r_rd0      <= w_gnt0 & ~bus.m0_we;
         r_rd1      <= w_gnt1 & ~bus.m1_we;
      end
   end

   assign bus.m0_gnt    = w_gnt0;
   assign bus.m1_gnt    = w_gnt1;
   assign bus.ram_wen   = w_ram_wen;
   assign bus.ram_adr   = w_ram_adr;
   assign bus.ram_dat_o = w_ram_dat;

   // Only one read is ever in flight, so the RAM output is steered to its
   // owner and zeroed elsewhere.
   assign bus.m0_rvalid = r_rd0;
   assign bus.m1_rvalid = r_rd1;
   assign bus.m0_rdata  = r_rd0 ? bus.ram_dat_i : '0;
   assign bus.m1_rdata  = r_rd1 ? bus.ram_dat_i : '0;

   assign bus.busy = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dmem_port_arbiter                                             |
// | Purpose : Directed and random stimulus for dmem_port_arbiter, compared     |
// |           against a transaction-level model of the arbitration rules.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_dmem_port_arbiter;

   localparam int ADDR_W   = 14;
   localparam int DATA_W   = 32;
   localparam int WAIT_MAX = 8;
   localparam int DEPTH    = 1 << ADDR_W;

   logic clock = 1'b0;
   logic rst;

   always #5 clock = ~clock;

   dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   function automatic logic [31:0] init_word(input int a);
      return (32'(a) * 32'h0001_0003) ^ 32'hA5A5_5A5A;
   endfunction

   // Synchronous-read RAM; unwritten words hold init_word(address).
   bit [31:0]   ram_mem [DEPTH];
   bit          ram_wr  [DEPTH];
   logic [31:0] ram_q;

   always @(posedge clock) begin
      if (bus.ram_wen) begin
         ram_mem[bus.ram_adr] <= bus.ram_dat_o;
         ram_wr[bus.ram_adr]  <= 1'b1;
      end
      ram_q <= ram_wr[bus.ram_adr] ? ram_mem[bus.ram_adr] : init_word(int'(bus.ram_adr));
   end
   assign bus.ram_dat_i = ram_q;

   // ------------------------------------------------------------------
   // Stimulus state and reference model
   // ------------------------------------------------------------------
   int          n_tests = 0;
   int          n_fail  = 0;

   bit          in_req  [2];
   bit          in_we   [2];
   bit          in_lock [2];
   logic [13:0] in_addr [2];
   logic [31:0] in_wd   [2];
   bit          pend    [2];

   int          m_own;          // -1 = nobody holds a lock
   int          m_last;         // master granted most recently
   int          m_blk   [2];    // consecutive cycles spent behind a lock
   bit          m_pv    [2];    // read return expected this cycle
   logic [31:0] m_pd    [2];
   bit [31:0]   exp_mem [DEPTH];
   bit          exp_wr  [DEPTH];
   int          exp_g;
   bit          exp_forced;

   function automatic logic [31:0] model_rd(input int a);
      return exp_wr[a] ? exp_mem[a] : init_word(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_own  = -1;
      m_last = 1;
      for (int i = 0; i < 2; i++) begin
         m_blk[i] = 0;
         m_pv[i]  = 1'b0;
         m_pd[i]  = '0;
      end
   endtask

   task automatic set_m(input int i, input bit req, input bit we, input bit lock,
                        input int addr, input logic [31:0] wd);
      in_req[i]  = req;
      in_we[i]   = we;
      in_lock[i] = lock;
      in_addr[i] = 14'(addr);
      in_wd[i]   = wd;
   endtask

   task automatic drive();
      bus.m0_req   = in_req[0];
      bus.m0_we    = in_we[0];
      bus.m0_lock  = in_lock[0];
      bus.m0_addr  = in_addr[0];
      bus.m0_wdata = in_wd[0];
      bus.m1_req   = in_req[1];
      bus.m1_we    = in_we[1];
      bus.m1_lock  = in_lock[1];
      bus.m1_addr  = in_addr[1];
      bus.m1_wdata = in_wd[1];
   endtask

   // Who gets the RAM this cycle, from the arbitration rules.
   task automatic predict();
      int o;
      exp_g      = -1;
      exp_forced = 1'b0;
      if (m_own < 0) begin
         if (in_req[0] && in_req[1]) exp_g = 1 - m_last;
         else if (in_req[0])         exp_g = 0;
         else if (in_req[1])         exp_g = 1;
      end else begin
         o = 1 - m_own;
         if (in_req[o] && m_blk[o] >= WAIT_MAX) begin
            exp_g      = o;
            exp_forced = 1'b1;
         end else if (in_req[m_own]) begin
            exp_g = m_own;
         end
      end
   endtask

   task automatic check_outputs();
      logic        e_wen;
      logic [31:0] e_adr;
      logic [31:0] e_dat;
      e_wen = (exp_g >= 0) ? in_we[exp_g]         : 1'b0;
      e_adr = (exp_g >= 0) ? 32'(in_addr[exp_g])  : 32'd0;
      e_dat = (exp_g >= 0) ? in_wd[exp_g]         : 32'd0;
      chk("m0_gnt",    bus.m0_gnt,    32'(exp_g == 0));
      chk("m1_gnt",    bus.m1_gnt,    32'(exp_g == 1));
      chk("ram_wen",   bus.ram_wen,   32'(e_wen));
      chk("ram_adr",   bus.ram_adr,   e_adr);
      chk("ram_dat_o", bus.ram_dat_o, e_dat);
      chk("m0_rvalid", bus.m0_rvalid, 32'(m_pv[0]));
      chk("m1_rvalid", bus.m1_rvalid, 32'(m_pv[1]));
      chk("m0_rdata",  bus.m0_rdata,  m_pv[0] ? m_pd[0] : 32'd0);
      chk("m1_rdata",  bus.m1_rdata,  m_pv[1] ? m_pd[1] : 32'd0);
      chk("busy",      bus.busy,      32'(m_own >= 0));
   endtask

   // Advance the model across the clock edge.
   task automatic commit();
      int prev;
      int nxt;
      prev = m_own;
      for (int i = 0; i < 2; i++) begin
         m_pv[i] = (exp_g == i) && !in_we[i];
         if (m_pv[i]) m_pd[i] = model_rd(int'(in_addr[i]));
      end
      nxt = -1;
      if (exp_g >= 0) begin
         if (in_we[exp_g]) begin
            exp_mem[in_addr[exp_g]] = in_wd[exp_g];
            exp_wr[in_addr[exp_g]]  = 1'b1;
         end
         m_last = exp_g;
         if (in_lock[exp_g] && !exp_forced) nxt = exp_g;
         pend[exp_g] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         if (prev >= 0 && i != prev && in_req[i] && exp_g != i && nxt == prev)
            m_blk[i] = m_blk[i] + 1;
         else
            m_blk[i] = 0;
      end
      m_own = nxt;
   endtask

   task automatic sample();
      drive();
      #1;
      predict();
      check_outputs();
   endtask

   task automatic advance();
      commit();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 2; i++) set_m(i, 1'b0, 1'b0, 1'b0, 0, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      drive();
      #1;
      model_reset();
      predict();
      check_outputs();
      chk("rst_busy", bus.busy, 32'd0);
      @(posedge clock);
      @(negedge clock);
      rst = 1'b0;
   endtask

   task automatic rand_inputs(input int p_req, input int p_lock);
      for (int i = 0; i < 2; i++) begin
         if (pend[i]) begin
            if ($urandom_range(0, 19) == 0) begin
               pend[i]   = 1'b0;
               in_req[i] = 1'b0;
            end
         end else if ($urandom_range(0, 99) < p_req) begin
            pend[i] = 1'b1;
            set_m(i, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < p_lock),
                  $urandom_range(0, 63), $urandom);
         end else begin
            in_req[i] = 1'b0;
         end
      end
   endtask

   initial begin
      idle_inputs();
      pend[0] = 1'b0;
      pend[1] = 1'b0;

      do_reset();

      // m0 reads 0x010 alone.
      set_m(0, 1'b1, 1'b0, 1'b0, 16'h010, 32'd0);
      sample();
      chk("t1_gnt0", bus.m0_gnt, 32'd1);
      chk("t1_adr",  bus.ram_adr, 32'h010);
      advance();
      idle_inputs();
      sample();
      chk("t1_rvalid", bus.m0_rvalid, 32'd1);
      chk("t1_rdata",  bus.m0_rdata, init_word(16'h010));
      chk("t1_m1_rvalid", bus.m1_rvalid, 32'd0);
      advance();

      // Both masters write continuously, no lock: strict alternation from m0.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_m(0, 1'b1, 1'b1, 1'b0, 16'h100 + (k + 1) / 2, {16'h1111, 16'((k + 1) / 2)});
         set_m(1, 1'b1, 1'b1, 1'b0, 16'h200 + k / 2,       {16'h2222, 16'(k / 2)});
         sample();
         chk("t2_gnt0", bus.m0_gnt, 32'((k % 2) == 0));
         chk("t2_wen",  bus.ram_wen, 32'd1);
         chk("t2_adr",  bus.ram_adr, ((k % 2) == 0) ? 32'h100 + 32'(k / 2) : 32'h200 + 32'(k / 2));
         advance();
      end

      // m1 burst of 4 writes, locked on the first 3, while m0 waits to read.
      for (int k = 0; k < 5; k++) begin
         if (k < 4) set_m(1, 1'b1, 1'b1, (k < 3), 16'h300 + k, 32'hB000_0000 + 32'(k));
         else       set_m(1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
         set_m(0, (k >= 1), 1'b0, 1'b0, 16'h050, 32'd0);
         sample();
         chk("t3_gnt1", bus.m1_gnt, 32'(k < 4));
         chk("t3_gnt0", bus.m0_gnt, 32'(k == 4));
         chk("t3_busy", bus.busy, 32'(k >= 1 && k <= 3));
         advance();
      end
      idle_inputs();
      sample();
      chk("t3_rvalid", bus.m0_rvalid, 32'd1);
      chk("t3_rdata",  bus.m0_rdata, init_word(16'h050));
      advance();

      // m1 holds its lock indefinitely; m0 is forced in on its 9th waiting cycle.
      for (int k = 0; k <= 10; k++) begin
         set_m(1, 1'b1, 1'b1, 1'b1, 16'h400 + ((k < 9) ? k : 9), 32'hC000_0000 + 32'(k));
         if (k == 10)     set_m(0, 1'b1, 1'b0, 1'b0, 16'h061, 32'd0);
         else if (k >= 1) set_m(0, 1'b1, 1'b0, 1'b0, 16'h060, 32'd0);
         sample();
         if (k >= 1 && k <= 8) chk("t4_blocked", bus.m0_gnt, 32'd0);
         if (k == 9) begin
            chk("t4_forced0", bus.m0_gnt, 32'd1);
            chk("t4_forced1", bus.m1_gnt, 32'd0);
            chk("t4_busy9",   bus.busy,   32'd1);
         end
         if (k == 10) begin
            chk("t4_regrant", bus.m1_gnt,    32'd1);
            chk("t4_busy10",  bus.busy,      32'd0);
            chk("t4_rvalid",  bus.m0_rvalid, 32'd1);
            chk("t4_rdata",   bus.m0_rdata,  init_word(16'h060));
         end
         advance();
      end
      idle_inputs();
      sample();
      advance();

      // Read granted, then reset mid-cycle while its rvalid is showing.
      set_m(0, 1'b1, 1'b0, 1'b0, 16'h020, 32'd0);
      sample();
      chk("t5_gnt0", bus.m0_gnt, 32'd1);
      advance();
      idle_inputs();
      sample();
      rst = 1'b1;
      #1;
      model_reset();
      chk("t5_rvalid", bus.m0_rvalid, 32'd0);
      chk("t5_rdata",  bus.m0_rdata,  32'd0);
      chk("t5_busy",   bus.busy,      32'd0);
      rst = 1'b0;
      predict();
      advance();
      set_m(0, 1'b1, 1'b0, 1'b0, 16'h021, 32'd0);
      set_m(1, 1'b1, 1'b0, 1'b0, 16'h022, 32'd0);
      sample();
      chk("t5_tie_m0", bus.m0_gnt, 32'd1);
      advance();
      set_m(0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
      sample();
      advance();

      // m1 takes the lock, then drops its request with nobody else waiting.
      set_m(1, 1'b1, 1'b1, 1'b1, 16'h500, 32'hD00D_0001);
      sample();
      chk("t6_gnt1", bus.m1_gnt, 32'd1);
      advance();
      idle_inputs();
      sample();
      chk("t6_nognt", bus.m1_gnt,  32'd0);
      chk("t6_wen",   bus.ram_wen, 32'd0);
      chk("t6_busy",  bus.busy,    32'd1);
      advance();
      sample();
      chk("t6_idle", bus.busy, 32'd0);
      advance();

      // Random traffic: light locking, then heavy locking to exercise the breaker.
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         rand_inputs(60, 30);
         sample();
         advance();
      end
      for (int n = 0; n < 1500; n++) begin
         rand_inputs(90, 85);
         sample();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
